// File: rtl/riscv_pu_axil_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pu_axil_mem_bridge
// Brief    : Memory-stage load/store handshake to a single-outstanding
//            AXI4-Lite master.
//            Optional response timeout via macro RISCV_AXIL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_pu_axil_mem_bridge #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int STRB_WIDTH     = DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic                  i_mem_wr_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_wr_data,
   input  logic [STRB_WIDTH-1:0] i_mem_wr_strb,
   input  logic                  i_mem_rd_ready,
   output logic                  o_mem_wr_ready,
   output logic                  o_mem_rd_valid,
   output logic [DATA_WIDTH-1:0] o_mem_rd_data,
   output logic                  o_bus_err,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

`ifdef RISCV_AXIL_TIMEOUT_EN
   localparam int                 c_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
`ifdef RISCV_AXIL_TIMEOUT_EN
      S_DRAIN   = 3'd6,
`endif
      S_ACK     = 3'd5
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
`ifdef RISCV_AXIL_TIMEOUT_EN
   logic [c_CNT_W-1:0]    r_tmo_cnt;
   logic                  r_timed_out;
   logic                  r_is_rd;
`endif

   // A channel counts as done if it already handshook or is handshaking now
   logic w_aw_done;
   logic w_w_done;
   assign w_aw_done = !m_axil_awvalid || m_axil_awready;
   assign w_w_done  = !m_axil_wvalid  || m_axil_wready;

   assign m_axil_awaddr = r_addr & c_ALIGN_MASK;
   assign m_axil_araddr = r_addr & c_ALIGN_MASK;
   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state        <= S_IDLE;
         r_addr         <= '0;
         m_axil_wdata   <= '0;
         m_axil_wstrb   <= '0;
         m_axil_awvalid <= 1'b0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
         o_mem_wr_ready <= 1'b0;
         o_mem_rd_valid <= 1'b0;
         o_mem_rd_data  <= '0;
         o_bus_err      <= 1'b0;
`ifdef RISCV_AXIL_TIMEOUT_EN
         r_tmo_cnt      <= '0;
         r_timed_out    <= 1'b0;
         r_is_rd        <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_mem_wr_valid) begin
                  r_addr         <= i_mem_addr;
                  m_axil_wdata   <= i_mem_wr_data;
                  m_axil_wstrb   <= i_mem_wr_strb;
                  m_axil_awvalid <= 1'b1;
                  m_axil_wvalid  <= 1'b1;
                  r_state        <= S_WR;
`ifdef RISCV_AXIL_TIMEOUT_EN
                  r_is_rd        <= 1'b0;
`endif
               end else if (i_mem_rd_ready) begin
                  r_addr         <= i_mem_addr;
                  m_axil_arvalid <= 1'b1;
                  r_state        <= S_RD_ADDR;
`ifdef RISCV_AXIL_TIMEOUT_EN
                  r_is_rd        <= 1'b1;
`endif
               end
            end
            S_WR: begin
               if (m_axil_awready) m_axil_awvalid <= 1'b0;
               if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  m_axil_bready <= 1'b1;
                  r_state       <= S_WR_RESP;
`ifdef RISCV_AXIL_TIMEOUT_EN
                  r_tmo_cnt     <= '0;
`endif
               end
            end
            S_WR_RESP: begin
               if (m_axil_bvalid) begin
                  m_axil_bready  <= 1'b0;
                  o_bus_err      <= (m_axil_bresp != 2'b00);
                  o_mem_wr_ready <= 1'b1;
                  r_state        <= S_ACK;
`ifdef RISCV_AXIL_TIMEOUT_EN
               end else if (r_tmo_cnt == c_CNT_LAST) begin
                  m_axil_bready  <= 1'b0;
                  o_bus_err      <= 1'b1;
                  o_mem_wr_ready <= 1'b1;
                  r_timed_out    <= 1'b1;
                  r_state        <= S_ACK;
               end else begin
                  r_tmo_cnt      <= r_tmo_cnt + 1'b1;
`endif
               end
            end
            S_RD_ADDR: begin
               if (m_axil_arready) begin
                  m_axil_arvalid <= 1'b0;
                  m_axil_rready  <= 1'b1;
                  r_state        <= S_RD_DATA;
`ifdef RISCV_AXIL_TIMEOUT_EN
                  r_tmo_cnt      <= '0;
`endif
               end
            end
            S_RD_DATA: begin
               // Data is forwarded even when the slave flags an error
               if (m_axil_rvalid) begin
                  m_axil_rready  <= 1'b0;
                  o_mem_rd_data  <= m_axil_rdata;
                  o_bus_err      <= (m_axil_rresp != 2'b00);
                  o_mem_rd_valid <= 1'b1;
                  r_state        <= S_ACK;
`ifdef RISCV_AXIL_TIMEOUT_EN
               end else if (r_tmo_cnt == c_CNT_LAST) begin
                  m_axil_rready  <= 1'b0;
                  o_mem_rd_data  <= '1;
                  o_bus_err      <= 1'b1;
                  o_mem_rd_valid <= 1'b1;
                  r_timed_out    <= 1'b1;
                  r_state        <= S_ACK;
               end else begin
                  r_tmo_cnt      <= r_tmo_cnt + 1'b1;
`endif
               end
            end
            S_ACK: begin
               o_mem_wr_ready <= 1'b0;
               o_mem_rd_valid <= 1'b0;
               o_bus_err      <= 1'b0;
`ifdef RISCV_AXIL_TIMEOUT_EN
               // After a timeout the late response must still be swallowed
               if (r_timed_out) begin
                  r_timed_out   <= 1'b0;
                  m_axil_rready <= r_is_rd;
                  m_axil_bready <= !r_is_rd;
                  r_state       <= S_DRAIN;
               end else begin
                  r_state       <= S_IDLE;
               end
`else
               r_state <= S_IDLE;
`endif
            end
`ifdef RISCV_AXIL_TIMEOUT_EN
            S_DRAIN: begin
               if ((m_axil_bready && m_axil_bvalid) || (m_axil_rready && m_axil_rvalid)) begin
                  m_axil_bready <= 1'b0;
                  m_axil_rready <= 1'b0;
                  r_state       <= S_IDLE;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
